// File: rtl/axi_master_pkg.sv
// Shared types and constants for the single-outstanding AXI initiator.
package axi_master_pkg;

    localparam int AXI_ID_W = 4;

    localparam logic [AXI_ID_W-1:0] DEF_IFU_ID = 4'd0;
    localparam logic [AXI_ID_W-1:0] DEF_LSU_ID = 4'd1;

    // Channel FSM: one transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B
    } state_t;

    // Which client owns the transaction currently in flight.
    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

endpackage

// File: rtl/axi_master_if.sv
// AXI channel bundle (AR/R/AW/W/B) between the initiator and the memory responder.
interface axi_master_if
    import axi_master_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic [AXI_ID_W-1:0] arid;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;

    logic [AXI_ID_W-1:0] awid;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arvalid,
        input  arready,
        input  rdata, rvalid,
        output rready,
        output awid, awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arvalid,
        output arready,
        output rdata, rvalid,
        input  rready,
        input  awid, awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_master_arb.sv
// Fixed-priority client arbiter (LSU over IFU) plus the owner register.
module axi_master_arb
    import axi_master_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   idle,
    input  logic   ifu_req,
    input  logic   lsu_req,
    output logic   ifu_ready,
    output logic   lsu_ready,
    output owner_t owner
);

    // Grant only while idle; LSU wins ties.
    always_comb begin
        lsu_ready = idle && lsu_req;
        ifu_ready = idle && ifu_req && !lsu_req;
    end

    // Remember who was granted so the read completion goes to the right client.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner <= OWN_IFU;
        end else if (lsu_ready) begin
            owner <= OWN_LSU;
        end else if (ifu_ready) begin
            owner <= OWN_IFU;
        end
    end

endmodule

// File: rtl/axi_master.sv
// Single-outstanding AXI initiator serving the IFU read port and the LSU port.
module axi_master
    import axi_master_pkg::*;
#(
    parameter int                  ADDR_W = 64,
    parameter int                  DATA_W = 64,
    parameter logic [AXI_ID_W-1:0] IFU_ID = DEF_IFU_ID,
    parameter logic [AXI_ID_W-1:0] LSU_ID = DEF_LSU_ID
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_ready,
    output logic                ifu_done,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_ready,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_rdata,

    axi_master_if.master        axi
);

    localparam int STRB_W = DATA_W / 8;

    state_t state, state_nx;
    owner_t owner;
    logic   idle;

    logic [AXI_ID_W-1:0] arid_q,    arid_nx;
    logic [ADDR_W-1:0]   araddr_q,  araddr_nx;
    logic                arvalid_q, arvalid_nx;
    logic                rready_q,  rready_nx;
    logic [AXI_ID_W-1:0] awid_q,    awid_nx;
    logic [ADDR_W-1:0]   awaddr_q,  awaddr_nx;
    logic                awvalid_q, awvalid_nx;
    logic [DATA_W-1:0]   wdata_q,   wdata_nx;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_nx;
    logic                wvalid_q,  wvalid_nx;
    logic                bready_q,  bready_nx;
    logic                ifu_done_q, ifu_done_nx;
    logic                lsu_done_q, lsu_done_nx;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_nx;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_nx;

    logic aw_hs;
    logic w_hs;

    assign idle = (state == IDLE);

    axi_master_arb u_arb (
        .clock     (clock),
        .reset     (reset),
        .idle      (idle),
        .ifu_req   (ifu_req),
        .lsu_req   (lsu_req),
        .ifu_ready (ifu_ready),
        .lsu_ready (lsu_ready),
        .owner     (owner)
    );

    // Per-channel handshakes seen during the write phase.
    always_comb begin
        aw_hs = awvalid_q && axi.awready;
        w_hs  = wvalid_q && axi.wready;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx     = state;
        arid_nx      = arid_q;
        araddr_nx    = araddr_q;
        arvalid_nx   = arvalid_q;
        rready_nx    = rready_q;
        awid_nx      = awid_q;
        awaddr_nx    = awaddr_q;
        awvalid_nx   = awvalid_q;
        wdata_nx     = wdata_q;
        wstrb_nx     = wstrb_q;
        wvalid_nx    = wvalid_q;
        bready_nx    = bready_q;
        ifu_done_nx  = 1'b0;
        lsu_done_nx  = 1'b0;
        ifu_rdata_nx = ifu_rdata_q;
        lsu_rdata_nx = lsu_rdata_q;

        case (state)
            IDLE: begin
                if (lsu_ready) begin
                    if (lsu_wen) begin
                        awid_nx    = LSU_ID;
                        awaddr_nx  = lsu_addr;
                        wdata_nx   = lsu_wdata;
                        wstrb_nx   = lsu_wstrb;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                        bready_nx  = 1'b1;
                        state_nx   = WR;
                    end else begin
                        arid_nx    = LSU_ID;
                        araddr_nx  = lsu_addr;
                        arvalid_nx = 1'b1;
                        state_nx   = AR;
                    end
                end else if (ifu_ready) begin
                    arid_nx    = IFU_ID;
                    araddr_nx  = ifu_addr;
                    arvalid_nx = 1'b1;
                    state_nx   = AR;
                end
            end

            AR: begin
                if (axi.arready) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                    state_nx   = R;
                end
            end

            R: begin
                if (axi.rvalid) begin
                    rready_nx = 1'b0;
                    state_nx  = IDLE;
                    if (owner == OWN_LSU) begin
                        lsu_rdata_nx = axi.rdata;
                        lsu_done_nx  = 1'b1;
                    end else begin
                        ifu_rdata_nx = axi.rdata;
                        ifu_done_nx  = 1'b1;
                    end
                end
            end

            WR: begin
                // An early B response ends the write even if AW/W are still open.
                if (axi.bvalid) begin
                    awvalid_nx  = 1'b0;
                    wvalid_nx   = 1'b0;
                    bready_nx   = 1'b0;
                    lsu_done_nx = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    if (aw_hs) begin
                        awvalid_nx = 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_nx = 1'b0;
                    end
                    if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
                        state_nx = B;
                    end
                end
            end

            B: begin
                if (axi.bvalid) begin
                    bready_nx   = 1'b0;
                    lsu_done_nx = 1'b1;
                    state_nx    = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Channel FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and handshake output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arid_q      <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            ifu_done_q  <= 1'b0;
            lsu_done_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            arid_q      <= arid_nx;
            araddr_q    <= araddr_nx;
            arvalid_q   <= arvalid_nx;
            rready_q    <= rready_nx;
            awid_q      <= awid_nx;
            awaddr_q    <= awaddr_nx;
            awvalid_q   <= awvalid_nx;
            wdata_q     <= wdata_nx;
            wstrb_q     <= wstrb_nx;
            wvalid_q    <= wvalid_nx;
            bready_q    <= bready_nx;
            ifu_done_q  <= ifu_done_nx;
            lsu_done_q  <= lsu_done_nx;
            ifu_rdata_q <= ifu_rdata_nx;
            lsu_rdata_q <= lsu_rdata_nx;
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = awid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    assign ifu_done  = ifu_done_q;
    assign lsu_done  = lsu_done_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_axi_master.sv
// Directed self-checking bench for axi_master.
module tb_axi_master;

    logic        clock;
    logic        reset;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_ready;
    logic        ifu_done;
    logic [63:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_wen;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_ready;
    logic        lsu_done;
    logic [63:0] lsu_rdata;

    int unsigned n_tests;
    int unsigned n_fail;

    logic [63:0] exp_ifu_rdata;
    logic [63:0] exp_lsu_rdata;

    axi_master_if #(.ADDR_W(64), .DATA_W(64)) axi ();

    axi_master #(
        .ADDR_W (64),
        .DATA_W (64),
        .IFU_ID (4'd0),
        .LSU_ID (4'd1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_ready (ifu_ready),
        .ifu_done  (ifu_done),
        .ifu_rdata (ifu_rdata),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wstrb (lsu_wstrb),
        .lsu_ready (lsu_ready),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .axi       (axi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One read through the AR/R channels; returns in the done cycle.
    task automatic run_read(input bit is_lsu, input logic [63:0] addr, input logic [63:0] data,
                            input int unsigned ar_wait, input int unsigned r_wait);
        logic [3:0] id;
        id = is_lsu ? 4'd1 : 4'd0;
        if (is_lsu) begin
            lsu_req  = 1'b1;
            lsu_wen  = 1'b0;
            lsu_addr = addr;
        end else begin
            ifu_req  = 1'b1;
            ifu_addr = addr;
        end
        #1;
        check("rd_lsu_ready", 64'(lsu_ready), 64'(is_lsu));
        check("rd_ifu_ready", 64'(ifu_ready), 64'(!is_lsu));
        step();
        if (is_lsu) begin
            lsu_req  = 1'b0;
            lsu_addr = '1;
        end else begin
            ifu_req  = 1'b0;
            ifu_addr = '1;
        end
        for (int unsigned i = 0; i <= ar_wait; i++) begin
            axi.arready = (i == ar_wait);
            #1;
            check("ar_arvalid", 64'(axi.arvalid), 64'd1);
            check("ar_araddr", axi.araddr, addr);
            check("ar_arid", 64'(axi.arid), 64'(id));
            check("ar_rready", 64'(axi.rready), 64'd0);
            check("ar_done", 64'({ifu_done, lsu_done}), 64'd0);
            check("ar_busy_ready", 64'({ifu_ready, lsu_ready}), 64'd0);
            step();
        end
        axi.arready = 1'b0;
        for (int unsigned j = 0; j <= r_wait; j++) begin
            axi.rvalid = (j == r_wait);
            axi.rdata  = (j == r_wait) ? data : ~data;
            #1;
            check("r_rready", 64'(axi.rready), 64'd1);
            check("r_arvalid", 64'(axi.arvalid), 64'd0);
            check("r_done", 64'({ifu_done, lsu_done}), 64'd0);
            step();
        end
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        if (is_lsu) exp_lsu_rdata = data;
        else        exp_ifu_rdata = data;
        #1;
        check("rd_lsu_done", 64'(lsu_done), 64'(is_lsu));
        check("rd_ifu_done", 64'(ifu_done), 64'(!is_lsu));
        check("rd_lsu_rdata", lsu_rdata, exp_lsu_rdata);
        check("rd_ifu_rdata", ifu_rdata, exp_ifu_rdata);
        check("rd_rready_low", 64'(axi.rready), 64'd0);
    endtask

    // One LSU write; responder events occur in the given cycles after acceptance.
    task automatic run_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int unsigned aw_cyc, input int unsigned w_cyc, input int unsigned b_cyc);
        lsu_req   = 1'b1;
        lsu_wen   = 1'b1;
        lsu_addr  = addr;
        lsu_wdata = data;
        lsu_wstrb = strb;
        #1;
        check("wr_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        lsu_addr  = '1;
        lsu_wdata = '1;
        lsu_wstrb = '1;
        for (int unsigned c = 1; c <= b_cyc; c++) begin
            axi.awready = (c == aw_cyc);
            axi.wready  = (c == w_cyc);
            axi.bvalid  = (c == b_cyc);
            #1;
            check("wr_awvalid", 64'(axi.awvalid), 64'(c <= aw_cyc));
            check("wr_wvalid", 64'(axi.wvalid), 64'(c <= w_cyc));
            check("wr_bready", 64'(axi.bready), 64'd1);
            check("wr_awaddr", axi.awaddr, addr);
            check("wr_awid", 64'(axi.awid), 64'd1);
            check("wr_wdata", axi.wdata, data);
            check("wr_wstrb", 64'(axi.wstrb), 64'(strb));
            check("wr_arvalid", 64'(axi.arvalid), 64'd0);
            check("wr_done_early", 64'(lsu_done), 64'd0);
            step();
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        #1;
        check("wr_lsu_done", 64'(lsu_done), 64'd1);
        check("wr_ifu_done", 64'(ifu_done), 64'd0);
        check("wr_valids_low", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        check("wr_lsu_rdata_kept", lsu_rdata, exp_lsu_rdata);
    endtask

    task automatic idle_cycle();
        step();
        #1;
        check("idle_done_low", 64'({ifu_done, lsu_done}), 64'd0);
        check("idle_valids_low", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_valids"}, 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        check({tag, "_done"}, 64'({ifu_done, lsu_done}), 64'd0);
        check({tag, "_araddr"}, axi.araddr, 64'd0);
        check({tag, "_awaddr"}, axi.awaddr, 64'd0);
        check({tag, "_wdata"}, axi.wdata, 64'd0);
        check({tag, "_ids_strb"}, 64'({axi.arid, axi.awid, axi.wstrb}), 64'd0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 64'd0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        exp_ifu_rdata = '0;
        exp_lsu_rdata = '0;
        reset     = 1'b1;
        ifu_req   = 1'b0;
        ifu_addr  = '0;
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        lsu_wstrb = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check_all_reset("rst");
        #2 reset = 1'b0;
        step();

        // LSU read, nominal latency
        run_read(1'b1, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 1, 0);
        idle_cycle();

        // IFU read; LSU data must stay
        run_read(1'b0, 64'h0000_0000_8000_0000, 64'hCAFE_F00D_1234_5678, 1, 0);
        idle_cycle();

        // Write: AW first, then W together with B (completes from WR)
        run_write(64'h0000_0000_8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1, 2, 2);
        idle_cycle();

        // Write: W first, then AW, then B from the B state
        run_write(64'h0000_0000_8000_0108, 64'hA5A5_5A5A_0102_0304, 8'hF0, 2, 1, 3);
        idle_cycle();

        // Both clients request together: LSU first, IFU accepted in LSU's done cycle
        ifu_req  = 1'b1;
        ifu_addr = 64'h0000_0000_8000_0080;
        run_read(1'b1, 64'h0000_0000_8000_0020, 64'h0F0E_0D0C_0B0A_0908, 1, 0);
        check("tie_ifu_ready_in_done", 64'(ifu_ready), 64'd1);
        run_read(1'b0, 64'h0000_0000_8000_0080, 64'h7766_5544_3322_1100, 1, 0);
        idle_cycle();

        // Backpressure on AR and R
        run_read(1'b1, 64'h0000_0000_8000_0200, 64'hFEDC_BA98_7654_3210, 5, 3);
        idle_cycle();

        // Reset during R with rvalid pending
        ifu_req  = 1'b1;
        ifu_addr = 64'h0000_0000_8000_0040;
        #1;
        check("rr_ifu_ready", 64'(ifu_ready), 64'd1);
        step();
        ifu_req = 1'b0;
        #1;
        check("rr_arvalid", 64'(axi.arvalid), 64'd1);
        step();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 64'h5555_AAAA_5555_AAAA;
        #1;
        check("rr_rready", 64'(axi.rready), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_all_reset("rr_async");
        exp_ifu_rdata = '0;
        exp_lsu_rdata = '0;
        step();
        check("rr_no_done_in_reset", 64'({ifu_done, lsu_done}), 64'd0);
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        #1 reset = 1'b0;
        step();
        check("rr_no_done_after", 64'({ifu_done, lsu_done}), 64'd0);
        check("rr_idle_rready", 64'(axi.rready), 64'd0);

        run_read(1'b0, 64'h0000_0000_8000_0300, 64'h0123_4567_89AB_CDEF, 1, 0);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
